// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
package arb_pkg;

  localparam int unsigned ARB_DEF_N   = 16;
  localparam int unsigned ARB_DEF_W   = 4;
  localparam int unsigned ARB_MAX_IDW = 8;
  localparam int unsigned ARB_MAX_N   = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Wide one-hot; callers size-cast the result down to their own N.
  function automatic logic [ARB_MAX_N-1:0] onehot_of(input logic [ARB_MAX_IDW-1:0] idx);
    return {{(ARB_MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority finder: first set request at or above i_ptr, wrapping to 0.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter  int N   = ARB_DEF_N,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic           o_found,
  output logic [IDW-1:0] o_winner
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  // Lower half holds requests at or above ptr; the upper half is the wrapped copy.
  assign w_dbl = {i_req, i_req & w_mask};

  always_comb begin
    logic           v_hit;
    logic [IDW-1:0] v_idx;
    v_hit = 1'b0;
    v_idx = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (!v_hit && w_dbl[i]) begin
        v_hit = 1'b1;
        v_idx = (i >= N) ? IDW'(i - N) : IDW'(i);
      end
    end
    o_found  = v_hit;
    o_winner = v_idx;
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter that holds a registered grant for a burst of
// up to weight beats, releasing early if the owner withdraws.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N = ARB_DEF_N,
  parameter int W = ARB_DEF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  input  logic [N*W-1:0]       weight_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_vld_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 last_o
);

  // state | meaning
  // IDLE  | no owner, arbitrate every cycle
  // GRANT | r_gnt_id owns the resource, r_credit beats remain

  localparam int IDW = $clog2(N);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_credit;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;

  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic [W-1:0]   w_weight [N];
  logic [W-1:0]   w_load_credit;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_owner_req;
  logic           w_release;
  logic           w_arb;

  for (genvar g = 0; g < N; g++) begin : g_weight
    assign w_weight[g] = weight_i[g*W +: W];
  end

  rr_priority_pick #(.N(N)) u_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_found  (w_found),
    .o_winner (w_winner)
  );

  assign w_load_credit = (w_weight[w_winner] == '0) ? W'(1) : w_weight[w_winner];
  assign w_ptr_nxt     = (w_winner == IDW'(N - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_owner_req = req_i[r_gnt_id];
    w_release   = (r_state == GRANT) && (!w_owner_req || (r_credit == W'(1)));
    w_arb       = (r_state == IDLE) || w_release;
    w_state_nxt = r_state;
    if (w_arb) begin
      w_state_nxt = w_found ? GRANT : IDLE;
    end
  end

  // Weight is sampled only at grant; mid-burst weight changes have no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_credit <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
    end else if (w_arb) begin
      if (w_found) begin
        r_gnt    <= N'(onehot_of(ARB_MAX_IDW'(w_winner)));
        r_gnt_id <= w_winner;
        r_credit <= w_load_credit;
        r_ptr    <= w_ptr_nxt;
      end else begin
        r_gnt    <= '0;
        r_gnt_id <= '0;
        r_credit <= '0;
      end
    end else if (r_state == GRANT) begin
      r_credit <= r_credit - 1'b1;
    end
  end

  always_comb begin
    gnt_o     = r_gnt;
    gnt_vld_o = (r_state == GRANT);
    gnt_id_o  = r_gnt_id;
    last_o    = (r_state == GRANT) && (r_credit == W'(1)) && w_owner_req;
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed-vector bench for wrr_burst_arbiter (N=16, W=4).
module tb_wrr_burst_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_i;
  logic [63:0] weight_i;
  logic [15:0] gnt_o;
  logic        gnt_vld_o;
  logic [3:0]  gnt_id_o;
  logic        last_o;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [15:0] req;
    logic [63:0] wt;
    logic        vld;
    logic [3:0]  id;
    logic        last;
  } vec_t;

  vec_t vq[$];

  wrr_burst_arbiter #(.N(16), .W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .weight_i  (weight_i),
    .gnt_o     (gnt_o),
    .gnt_vld_o (gnt_vld_o),
    .gnt_id_o  (gnt_id_o),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wset(input int a, input logic [3:0] va,
                                       input int b, input logic [3:0] vb);
    logic [63:0] w;
    w = {16{4'h1}};
    w[a*4 +: 4] = va;
    w[b*4 +: 4] = vb;
    return w;
  endfunction

  function automatic logic [15:0] oh(input logic v, input logic [3:0] id);
    logic [15:0] one;
    one = 16'h0001;
    return v ? (one << id) : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic ev, input logic [3:0] eid, input logic el);
    logic [15:0] eg;
    eg = oh(ev, eid);
    n_tot++;
    if ({gnt_o, gnt_vld_o, gnt_id_o, last_o} === {eg, ev, eid, el}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gnt=%h vld=%b id=%0d last=%b, want gnt=%h vld=%b id=%0d last=%b",
               nm, gnt_o, gnt_vld_o, gnt_id_o, last_o, eg, ev, eid, el);
    end
  endtask

  task automatic add(input logic [15:0] rq, input logic [63:0] wt,
                     input logic v, input logic [3:0] id, input logic l);
    vec_t e;
    e.req  = rq;
    e.wt   = wt;
    e.vld  = v;
    e.id   = id;
    e.last = l;
    vq.push_back(e);
  endtask

  task automatic step(input string nm, input logic v, input logic [3:0] id, input logic l);
    @(posedge clk);
    #1;
    chk(nm, v, id, l);
  endtask

  initial begin
    logic [63:0] w_a, w_b, w_c, w_c15, w_e, w_all1;
    w_all1 = {16{4'h1}};
    w_a    = wset(3, 4'd2, 3, 4'd2);
    w_b    = w_all1;
    w_c    = wset(0, 4'd3, 15, 4'd1);
    w_c15  = wset(0, 4'd15, 15, 4'd1);
    w_e    = wset(2, 4'd0, 7, 4'd2);

    // sole requester 3, weight 2
    add(16'h0008, w_a, 1, 3, 0);
    add(16'h0008, w_a, 1, 3, 1);
    add(16'h0008, w_a, 1, 3, 0);
    add(16'h0008, w_a, 1, 3, 1);
    // fair alternation 0/4, weight 1
    add(16'h0011, w_b, 1, 4, 1);
    add(16'h0011, w_b, 1, 0, 1);
    add(16'h0011, w_b, 1, 4, 1);
    add(16'h0011, w_b, 1, 0, 1);
    // wrap-around weighting from ptr=1; weight[0] bumped mid-burst is ignored
    add(16'h8001, w_c,   1, 15, 1);
    add(16'h8001, w_c,   1, 0,  0);
    add(16'h8001, w_c15, 1, 0,  0);
    add(16'h8001, w_c15, 1, 0,  1);
    add(16'h8001, w_c,   1, 15, 1);
    add(16'h8001, w_c,   1, 0,  0);
    // zero weight on requester 2 gives one beat
    add(16'h0084, w_e, 1, 2, 1);
    add(16'h0084, w_e, 1, 7, 0);
    add(16'h0084, w_e, 1, 7, 1);
    add(16'h0084, w_e, 1, 2, 1);
    add(16'h0000, w_e, 0, 0, 0);
    add(16'h0000, w_e, 0, 0, 0);

    reset    = 1'b1;
    req_i    = 16'hFFFF;
    weight_i = w_all1;
    @(negedge clk);
    chk("rst_init", 0, 0, 0);
    reset = 1'b0;
    req_i = 16'h0000;
    step("idle_after_rst", 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req_i    = vq[i].req;
      weight_i = vq[i].wt;
      step($sformatf("vec%0d", i), vq[i].vld, vq[i].id, vq[i].last);
    end

    // early withdrawal: owner 5 (weight 8) drops after two beats, 9 waits
    @(negedge clk);
    req_i    = 16'h0220;
    weight_i = wset(5, 4'd8, 9, 4'd4);
    step("wd_grant5", 1, 5, 0);
    @(negedge clk);
    step("wd_beat1", 1, 5, 0);
    @(negedge clk);
    step("wd_beat2", 1, 5, 0);
    @(negedge clk);
    req_i = 16'h0200;
    #1;
    chk("wd_hold5", 1, 5, 0);
    step("wd_grant9", 1, 9, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      step($sformatf("wd_9_beat%0d", k), 1, 9, (k == 2));
    end

    // reset mid-burst with owner 6 holding 3 credits
    @(negedge clk);
    req_i    = 16'h0040;
    weight_i = wset(6, 4'd5, 6, 4'd5);
    step("rb_grant6", 1, 6, 0);
    @(negedge clk);
    step("rb_c4", 1, 6, 0);
    @(negedge clk);
    step("rb_c3", 1, 6, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("rb_async", 0, 0, 0);
    step("rb_hold", 0, 0, 0);
    @(negedge clk);
    reset    = 1'b0;
    req_i    = 16'h0041;
    weight_i = w_all1;
    step("rb_ptr0", 1, 0, 1);
    @(negedge clk);
    step("rb_next6", 1, 6, 1);
    @(negedge clk);
    req_i = 16'h0000;
    step("final_idle", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
